// File: rtl/asyn_fifo_wptr_full.sv
// Write-side pointer and flag logic of an async FIFO; Gray pointer out, full/almost-full/level registered.
// Optional sticky overflow flag built only when ASYN_FIFO_WR_OVERFLOW_EN is defined.
module asyn_fifo_wptr_full #(
   parameter int ADDR_WIDTH         = 6,
   parameter int ALMOST_FULL_THRESH = 56
) (
   input  logic                  write_clk,
   input  logic                  write_rst_n,
   input  logic                  write_en,
   input  logic [ADDR_WIDTH:0]   sync_read_to_write,
   output logic [ADDR_WIDTH-1:0] write_addr,
   output logic [ADDR_WIDTH:0]   write_ptr,
   output logic                  write_full,
   output logic                  write_almost_full,
   output logic [ADDR_WIDTH:0]   write_level,
   output logic                  write_overflow
);

   localparam int PW = ADDR_WIDTH + 1;
   localparam logic [PW-1:0] AF_TH = PW'(ALMOST_FULL_THRESH);

   logic [PW-1:0] wbin_q, wbin_d;
   logic [PW-1:0] wptr_q, wgray_d;
   logic [PW-1:0] level_q, diff_d;
   logic [PW-1:0] rbin;
   logic [PW-1:0] full_cmp;
   logic          full_q, full_d;
   logic          afull_q, afull_d;
   logic          write_accept;

   assign write_accept = write_en & ~full_q;

   always_comb begin
      rbin = '0;
      for (int i = 0; i < PW; i++) begin
         rbin[i] = ^(sync_read_to_write >> i);
      end
   end

   // Full when the next write pointer laps the read pointer: top two Gray bits inverted.
   assign full_cmp = {~sync_read_to_write[ADDR_WIDTH:ADDR_WIDTH-1],
                      sync_read_to_write[ADDR_WIDTH-2:0]};

   always_comb begin
      wbin_d  = wbin_q + {{ADDR_WIDTH{1'b0}}, write_accept};
      wgray_d = (wbin_d >> 1) ^ wbin_d;
      diff_d  = wbin_d - rbin;
      full_d  = (wgray_d == full_cmp);
      afull_d = (diff_d >= AF_TH);
   end

   always_ff @(posedge write_clk) begin
      if (!write_rst_n) begin
         wbin_q  <= '0;
         wptr_q  <= '0;
         level_q <= '0;
         full_q  <= 1'b0;
         afull_q <= 1'b0;
      end else begin
         wbin_q  <= wbin_d;
         wptr_q  <= wgray_d;
         level_q <= diff_d;
         full_q  <= full_d;
         afull_q <= afull_d;
      end
   end

   assign write_addr        = wbin_q[ADDR_WIDTH-1:0];
   assign write_ptr         = wptr_q;
   assign write_full        = full_q;
   assign write_almost_full = afull_q;
   assign write_level       = level_q;

`ifdef ASYN_FIFO_WR_OVERFLOW_EN
   logic ovf_q;

   always_ff @(posedge write_clk) begin
      if (!write_rst_n) begin
         ovf_q <= 1'b0;
      end else if (write_en && full_q) begin
         ovf_q <= 1'b1;
      end
   end

   assign write_overflow = ovf_q;
`else
   assign write_overflow = 1'b0;
`endif

endmodule

// File: tb/tb_asyn_fifo_wptr_full.sv
// Scoreboard bench for asyn_fifo_wptr_full: stimulus queues expected outputs, monitor compares on negedge.
module tb_asyn_fifo_wptr_full;

`ifdef ASYN_FIFO_WR_OVERFLOW_EN
   localparam logic OVF_EN = 1'b1;
`else
   localparam logic OVF_EN = 1'b0;
`endif

   localparam logic [5:0] M_ADDR  = 6'h01;
   localparam logic [5:0] M_PTR   = 6'h02;
   localparam logic [5:0] M_FULL  = 6'h04;
   localparam logic [5:0] M_AFULL = 6'h08;
   localparam logic [5:0] M_LEVEL = 6'h10;
   localparam logic [5:0] M_OVF   = 6'h20;
   localparam logic [5:0] M_ALL   = 6'h3f;

   logic       write_clk;
   logic       write_rst_n;
   logic       write_en;
   logic [6:0] sync_read_to_write;
   logic [5:0] write_addr;
   logic [6:0] write_ptr;
   logic       write_full;
   logic       write_almost_full;
   logic [6:0] write_level;
   logic       write_overflow;

   asyn_fifo_wptr_full #(.ADDR_WIDTH(6), .ALMOST_FULL_THRESH(56)) dut (
      .write_clk          (write_clk),
      .write_rst_n        (write_rst_n),
      .write_en           (write_en),
      .sync_read_to_write (sync_read_to_write),
      .write_addr         (write_addr),
      .write_ptr          (write_ptr),
      .write_full         (write_full),
      .write_almost_full  (write_almost_full),
      .write_level        (write_level),
      .write_overflow     (write_overflow)
   );

   typedef struct {
      string      name;
      int         cyc;
      logic [5:0] mask;
      logic [5:0] addr;
      logic [6:0] ptr;
      logic       full;
      logic       afull;
      logic [6:0] level;
      logic       ovf;
   } exp_t;

   exp_t sb[$];
   int   cyc = 0;
   int   checks = 0;
   int   errors = 0;

   initial write_clk = 1'b0;
   always #5 write_clk = ~write_clk;
   always @(posedge write_clk) cyc <= cyc + 1;

   function automatic logic [6:0] g(input int v);
      logic [6:0] b;
      b = v[6:0];
      return b ^ (b >> 1);
   endfunction

   task automatic chk(input string nm, input string f, input int act, input int expv);
      checks++;
      if (act != expv) begin
         errors++;
         $display("FAIL %s.%s cycle %0d: got %0d expected %0d", nm, f, cyc, act, expv);
      end
   endtask

   always @(negedge write_clk) begin
      while (sb.size() > 0 && sb[0].cyc == cyc) begin
         exp_t e;
         e = sb.pop_front();
         if (e.mask[0]) chk(e.name, "addr",  int'(write_addr),        int'(e.addr));
         if (e.mask[1]) chk(e.name, "ptr",   int'(write_ptr),         int'(e.ptr));
         if (e.mask[2]) chk(e.name, "full",  int'(write_full),        int'(e.full));
         if (e.mask[3]) chk(e.name, "afull", int'(write_almost_full), int'(e.afull));
         if (e.mask[4]) chk(e.name, "level", int'(write_level),       int'(e.level));
         if (e.mask[5]) chk(e.name, "ovf",   int'(write_overflow),    int'(e.ovf));
      end
   end

   task automatic tick();
      @(posedge write_clk);
      #1;
   endtask

   task automatic expect_out(input string nm, input logic [5:0] m, input logic [5:0] a,
                             input logic [6:0] p, input logic f, input logic af,
                             input logic [6:0] lv, input logic ov);
      exp_t e;
      e.name = nm; e.cyc = cyc; e.mask = m; e.addr = a; e.ptr = p;
      e.full = f; e.afull = af; e.level = lv; e.ovf = ov;
      sb.push_back(e);
   endtask

   initial begin
      write_rst_n = 1'b0;
      write_en = 1'b1;
      sync_read_to_write = '0;

      // Reset held with write_en asserted
      tick(); expect_out("rst0", M_ALL, 6'd0, 7'd0, 1'b0, 1'b0, 7'd0, 1'b0);
      tick(); expect_out("rst1", M_ALL, 6'd0, 7'd0, 1'b0, 1'b0, 7'd0, 1'b0);
      write_rst_n = 1'b1; write_en = 1'b0;
      tick(); expect_out("idle", M_ALL, 6'd0, 7'd0, 1'b0, 1'b0, 7'd0, 1'b0);

      // Fill 64 entries against a stationary read pointer
      write_en = 1'b1;
      for (int k = 1; k <= 64; k++) begin
         tick();
         expect_out("fill", M_ALL, 6'(k % 64), g(k), (k == 64), (k >= 56), 7'(k), 1'b0);
      end

      // Write attempt while full is ignored
      tick(); expect_out("ovr", M_ALL, 6'd0, 7'b1100000, 1'b1, 1'b1, 7'd64, OVF_EN);
      write_en = 1'b0;

      // Read pointer advances by one
      sync_read_to_write = 7'b0000001;
      tick(); expect_out("drain", M_ALL, 6'd0, 7'b1100000, 1'b0, 1'b1, 7'd63, OVF_EN);
      write_en = 1'b1;
      tick(); expect_out("refill", M_ALL, 6'd1, 7'h61, 1'b1, 1'b1, 7'd64, OVF_EN);
      write_en = 1'b0;
      tick(); expect_out("hold", M_ALL, 6'd1, 7'h61, 1'b1, 1'b1, 7'd64, OVF_EN);

      // Reset clears everything including sticky overflow
      write_rst_n = 1'b0;
      tick(); expect_out("rst2", M_ALL, 6'd0, 7'd0, 1'b0, 1'b0, 7'd0, 1'b0);
      write_rst_n = 1'b1; sync_read_to_write = '0; write_en = 1'b1;
      for (int k = 1; k <= 10; k++) begin
         tick(); expect_out("w10", M_ADDR | M_LEVEL, 6'(k), 7'd0, 1'b0, 1'b0, 7'(k), 1'b0);
      end

      // Mid-operation reset
      write_rst_n = 1'b0;
      tick(); expect_out("midrst", M_ALL, 6'd0, 7'd0, 1'b0, 1'b0, 7'd0, 1'b0);
      write_rst_n = 1'b1; write_en = 1'b0;
      tick(); expect_out("post", M_ALL, 6'd0, 7'd0, 1'b0, 1'b0, 7'd0, 1'b0);
      write_en = 1'b1;
      tick(); expect_out("first", M_ADDR | M_PTR | M_LEVEL | M_FULL, 6'd1, g(1), 1'b0, 1'b0, 7'd1, 1'b0);

      // Walk to wbin=127 with the read pointer trailing by one
      for (int k = 2; k <= 127; k++) begin
         sync_read_to_write = g(k - 1);
         tick(); expect_out("track", M_ALL, 6'(k % 64), g(k), 1'b0, 1'b0, 7'd1, 1'b0);
      end

      // Wrap 127 -> 0 with read pointer at binary 100
      sync_read_to_write = 7'h56;
      tick(); expect_out("wrap", M_ALL, 6'd0, 7'd0, 1'b0, 1'b0, 7'd28, 1'b0);
      write_en = 1'b0;

      repeat (3) @(posedge write_clk);
      #1;
      checks++;
      if (sb.size() != 0) begin
         errors++;
         $display("FAIL scoreboard_drain: %0d entries left, expected 0", sb.size());
      end
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/asyn_fifo_wptr_full.md
ASYN_FIFO_WPTR_FULL -- requirements
Module: asyn_fifo_wptr_full

Interface
REQ-001 The block SHALL have parameter ADDR_WIDTH, default 6, meaning FIFO depth is 2**ADDR_WIDTH; legal range is 2 or greater.
REQ-002 The block SHALL have parameter ALMOST_FULL_THRESH, default 56, meaning the occupancy at which write_almost_full asserts; legal range is 1 to 2**ADDR_WIDTH.
REQ-003 write_clk  input  1  sole clock; all state updates on its rising edge.
REQ-004 write_rst_n  input  1  synchronous, active-low reset, sampled on the rising edge of write_clk.
REQ-005 write_en  input  1  write request from the producer.
REQ-006 sync_read_to_write  input  ADDR_WIDTH+1  Gray-coded read pointer, already synchronized into the write_clk domain.
REQ-007 write_addr  output  ADDR_WIDTH  binary write address to the dual-port RAM.
REQ-008 write_ptr  output  ADDR_WIDTH+1  registered Gray write pointer, sent to the read-domain synchronizer.
REQ-009 write_full  output  1  registered full flag.
REQ-010 write_almost_full  output  1  registered almost-full flag.
REQ-011 write_level  output  ADDR_WIDTH+1  registered, conservative occupancy count.
REQ-012 write_overflow  output  1  sticky overflow flag; the port is always present.

Function
REQ-013 A write SHALL be accepted in a cycle when write_en=1 and write_full=0; this is write_accept.
REQ-014 The internal binary pointer wbin (ADDR_WIDTH+1 bits) SHALL increment by 1 on write_accept and wrap modulo 2**(ADDR_WIDTH+1).
REQ-015 write_addr SHALL equal wbin[ADDR_WIDTH-1:0]; the RAM write for an accepted cycle uses the current write_addr.
REQ-016 write_ptr SHALL be registered to (wbin_next>>1)^wbin_next, so it changes exactly one bit per accepted write.
REQ-017 rbin SHALL be the combinational Gray-to-binary conversion of sync_read_to_write.
REQ-018 write_full SHALL be registered to the result of comparing Gray(wbin_next) with {~sync_read_to_write[ADDR_WIDTH:ADDR_WIDTH-1], sync_read_to_write[ADDR_WIDTH-2:0]}; it asserts the cycle after the write that fills the FIFO.
REQ-019 write_level SHALL be registered to (wbin_next - rbin) modulo 2**(ADDR_WIDTH+1).
REQ-020 write_almost_full SHALL be registered to (wbin_next - rbin) >= ALMOST_FULL_THRESH.
REQ-021 Full boundary: write_en while write_full=1 SHALL be ignored; wbin, write_addr and write_ptr hold.
REQ-022 Read-pointer change plus write in the same cycle: flags SHALL use that cycle's sync_read_to_write; write_full deasserts the cycle after the read pointer advances, unless a write that same cycle refills the FIFO.
REQ-023 Wrap-around: correct level and full behaviour SHALL hold across the 2**(ADDR_WIDTH+1)-1 -> 0 transition of wbin.

Reset
REQ-024 When write_rst_n=0 at a rising edge, the block SHALL clear wbin, write_ptr, write_full, write_almost_full, write_level and write_overflow to 0, regardless of write_en.
REQ-025 Reset mid-operation SHALL discard all occupancy; the first accepted write after reset uses write_addr 0.

Configuration
REQ-026 With macro ASYN_FIFO_WR_OVERFLOW_EN defined, write_overflow SHALL set on the edge after a cycle with write_en=1 and write_full=1, and stay set until reset.
REQ-027 Without ASYN_FIFO_WR_OVERFLOW_EN, write_overflow SHALL be tied to 0 and no overflow register is built.

Verification (ADDR_WIDTH=6, ALMOST_FULL_THRESH=56)
REQ-028 Reset: drive write_rst_n=0 for 2 cycles with write_en=1 -> all outputs 0; write_addr stays 0 after release with write_en=0.
REQ-029 Fill: hold sync_read_to_write=0, then do 64 back-to-back writes -> after the 56th write, write_almost_full=1 and write_level=56; after the 64th write, write_full=1, write_level=64 and write_ptr=7'b1100000; a 65th write_en leaves write_addr=0.
REQ-030 Drain observe: from full, set sync_read_to_write=7'b0000001 (binary 1) -> next cycle write_full=0 and write_level=63; one write -> write_full=1 again next cycle.
REQ-031 Wrap: track the read pointer so the FIFO never fills until wbin=127, then set sync_read_to_write=7'h56 (binary 100) and write once -> write_addr=0, write_ptr=0, write_level=28, write_full=0.
REQ-032 Overflow: from full, pulse write_en for 1 cycle -> write_overflow=1 the next cycle and held through later reads; cleared only by write_rst_n=0. Without the macro it stays 0.
REQ-033 Mid-operation reset: after 10 writes, assert write_rst_n=0 for 1 cycle -> write_addr=0, write_level=0 and all flags 0 on the following cycle.
